// File: rtl/ehgu_fifo_out_buf.sv
// rtl/ehgu_fifo_out_buf.sv - 2-entry register queue holding RAM read data in front of the output port
module ehgu_fifo_out_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       cnt_o
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  head_q, head_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  tail;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    // Tail is taken from the pre-pop state so a simultaneous push/pop keeps order.
    tail   = head_q ^ cnt_q[0];
    if (push_i) mem_d[tail] = push_data_i;
    if (pop_i)  head_d = ~head_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[head_q];
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/ehgu_fifo_ctrl.sv
// rtl/ehgu_fifo_ctrl.sv - show-ahead FIFO controller over a 1-cycle-latency dual-port RAM
module ehgu_fifo_ctrl #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 3)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ram_wenable,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_renable,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [CW-1:0]    count
);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic          rd_pend_q;
  logic [1:0]    buf_cnt;
  logic          push, pop, issue;
  logic [2:0]    buf_occ;

  ehgu_fifo_out_buf #(.WIDTH(WIDTH)) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (ram_rdata),
    .pop_i       (pop),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .cnt_o       (buf_cnt)
  );

  assign in_ready = !rst && (ram_cnt_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Slots already spoken for in the output buffer, including the read in flight.
  assign buf_occ  = {1'b0, buf_cnt} + {2'b00, rd_pend_q};
  assign issue    = !rst && (ram_cnt_q != '0) && (buf_occ < (3'd2 + {2'b00, pop}));

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, issue};
    if (push) wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
    if (issue) rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= issue;
    end
  end

  assign ram_wenable = push;
  assign ram_waddr   = wptr_q;
  assign ram_wdata   = in_data;
  assign ram_renable = issue;
  assign ram_raddr   = rptr_q;
  assign count       = ram_cnt_q + {{(CW-1){1'b0}}, rd_pend_q} + {{(CW-2){1'b0}}, buf_cnt};

endmodule

// File: tb/tb_ehgu_fifo_ctrl.sv
// tb/tb_ehgu_fifo_ctrl.sv - scoreboard bench for ehgu_fifo_ctrl with a behavioural dual-port RAM
module tb_ehgu_fifo_ctrl;

  localparam int DEPTH = 3;
  localparam int WIDTH = 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 3);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             ram_wenable;
  logic [AW-1:0]    ram_waddr;
  logic [WIDTH-1:0] ram_wdata;
  logic             ram_renable;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic [CW-1:0]    count;

  int n_checks = 0;
  int n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  int exp_w = 0;
  int exp_r = 0;

  always #5 clk = ~clk;

  ehgu_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .ram_wenable (ram_wenable),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .ram_renable (ram_renable),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata),
    .count       (count)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_v_q = 1'b0;
  logic [WIDTH-1:0] rd_data_q = '0;

  always @(posedge clk) begin
    if (ram_wenable) mem[ram_waddr] <= ram_wdata;
    rd_v_q <= ram_renable;
    if (ram_renable) rd_data_q <= mem[ram_raddr];
  end

  assign ram_rdata = rd_v_q ? rd_data_q : {WIDTH{1'bx}};

  always @(negedge clk) begin
    logic [WIDTH-1:0] e;
    if (rst) begin
      exp_q.delete();
      exp_w = 0;
      exp_r = 0;
    end else begin
      n_checks++;
      if (int'(count) != exp_q.size()) begin
        n_fail++;
        $display("FAIL count_track: count=%0d expected=%0d", count, exp_q.size());
      end
      if (ram_renable && ram_wenable && ram_raddr == ram_waddr) begin
        n_fail++;
        $display("FAIL ram_contention: raddr=%0d waddr=%0d", ram_raddr, ram_waddr);
      end
      if (ram_wenable) begin
        n_checks++;
        if (int'(ram_waddr) != exp_w) begin
          n_fail++;
          $display("FAIL waddr_seq: waddr=%0d expected=%0d", ram_waddr, exp_w);
        end
        exp_w = (exp_w + 1) % DEPTH;
      end
      if (ram_renable) begin
        n_checks++;
        if (int'(ram_raddr) != exp_r) begin
          n_fail++;
          $display("FAIL raddr_seq: raddr=%0d expected=%0d", ram_raddr, exp_r);
        end
        exp_r = (exp_r + 1) % DEPTH;
      end
      if (out_valid && $isunknown(out_data)) begin
        n_fail++;
        $display("FAIL out_data_x: out_data=%h while out_valid", out_data);
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: out_data=%h with empty scoreboard", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL data_order: out_data=%h expected=%h", out_data, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || ram_wenable !== 1'b0 ||
        ram_renable !== 1'b0 || ram_waddr !== '0 || ram_raddr !== '0 || count !== '0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b out_data=%h wen=%b ren=%b waddr=%0d raddr=%0d count=%0d required all 0",
               in_ready, out_valid, out_data, ram_wenable, ram_renable, ram_waddr, ram_raddr, count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== (k == 3)) begin
        n_fail++;
        $display("FAIL latency_valid: cycle t+%0d out_valid=%b required %b", k, out_valid, (k == 3));
      end
      n_checks++;
      if (int'(count) != ((k == 4) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL latency_count: cycle t+%0d count=%0d required %0d", k, count, (k == 4) ? 0 : 1);
      end
      if (k == 3) begin
        n_checks++;
        if (out_data !== 8'h11) begin
          n_fail++;
          $display("FAIL latency_data: out_data=%h required 11", out_data);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    logic acc;
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready: beat %0d in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_data = 8'h06;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || int'(count) != 5) begin
        n_fail++;
        $display("FAIL fill_full: in_ready=%b count=%0d required 0 and 5", in_ready, count);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!acc) begin
      n_fail++;
      $display("FAIL fill_release: beat 06 accepted=%b required 1", acc);
    end
    for (int k = 0; k < 20 && count != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (count !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fill_drain: count=%0d pending=%0d required 0", count, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready: cycle %0d in_ready=%b required 1", k, in_ready);
      end
      if (k >= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || int'(count) != 3) begin
          n_fail++;
          $display("FAIL stream_steady: cycle %0d out_valid=%b count=%0d required 1 and 3", k, out_valid, count);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && count != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (count !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: count=%0d pending=%0d required 0", count, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int sent = 0;
    for (int cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      out_ready = $urandom_range(0, 1) != 0;
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (sent != 100) begin
      n_fail++;
      $display("FAIL random_sent: accepted=%0d required 100", sent);
    end
    for (int k = 0; k < 20 && count != 0; k++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (count !== '0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_drain: count=%0d pending=%0d required 0", count, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic seen;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'hB0 + WIDTH'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (int'(count) != 4) begin
      n_fail++;
      $display("FAIL midreset_pre: count=%0d required 4", count);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_post: count=%0d out_valid=%b in_ready=%b required 0,0,1", count, out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n_checks++;
        if (out_data !== 8'hA5) begin
          n_fail++;
          $display("FAIL midreset_first: out_data=%h required a5", out_data);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midreset_timeout: out_valid never rose after reset");
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_back_to_back();
    test_random();
    test_mid_reset();
    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
